button_input_reader: RTL
========================

Name: button_input_reader

Overview:
- Input-side counterpart to the board's free-running LED blink output.
- Samples one asynchronous pushbutton/switch board pin in the internal-oscillator domain (OSCH, 2.08 MHz nominal) and synchronises and debounces it.
- Emits single-cycle press, release and long-press events, plus a press-duration measurement held under a valid/ack handshake for downstream logic.

Parameters:
- DEBOUNCE_CYCLES, 20800, consecutive stable samples needed to accept a level change (10 ms at 2.08 MHz); legal range >= 2.
- LONG_PRESS_CYCLES, 2080000, held duration that fires long_pulse (1 s); must exceed DEBOUNCE_CYCLES.
- DUR_WIDTH, 24, width of the duration counter and dur_count.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.

Ports:
- clk  input  1  oscillator clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion is async, deassertion is sync to clk.
- btn_in  input  1  raw board pin, asynchronous to clk, may bounce.
- btn_level  output  1  debounced pressed level (1 = pressed).
- press_pulse  output  1  one-cycle strobe on accepted press.
- release_pulse  output  1  one-cycle strobe on accepted release.
- long_pulse  output  1  one-cycle strobe, at most once per press.
- dur_valid  output  1  dur_count holds an unconsumed measurement.
- dur_count  output  DUR_WIDTH  last press duration in clk cycles.
- dur_ack  input  1  consumer accepts the measurement.
- dur_overrun  output  1  sticky: a measurement was overwritten while unacknowledged.

Behaviour:
- Reset, asynchronous and immediate, also when asserted mid-press:
  - state = IDLE; all outputs 0; synchroniser flops = released (normalised 0); counters = 0.
  - No pulses fire on or after reset deassertion unless a new press is accepted.
- Input path: normalised sample s = btn_in XOR ACTIVE_LOW, passed through a 2-flop synchroniser. All decisions use the synchronised s; btn_in-to-decision latency is 2 cycles.
- Debounce counter: width clog2(DEBOUNCE_CYCLES+1); cleared on every state entry.
- IDLE:
  - s = 1 -> PRESS_DEB, count = 1.
- PRESS_DEB:
  - s = 0 -> IDLE; glitch rejected, no outputs change.
  - s = 1 and count reaches DEBOUNCE_CYCLES -> PRESSED. In this same cycle (cycle N): btn_level = 1, press_pulse = 1 for exactly 1 cycle.
  - Otherwise count++.
- PRESSED:
  - s = 0 -> RELEASE_DEB, count = 1.
- RELEASE_DEB:
  - s = 1 -> PRESSED; bounce rejected, no release, duration keeps running.
  - s = 0 for DEBOUNCE_CYCLES consecutive cycles -> IDLE. In this same cycle (cycle R): btn_level = 0, release_pulse = 1 for exactly 1 cycle.
- Duration:
  - The counter runs while state is PRESSED or RELEASE_DEB.
  - Measurement = R - N (number of cycles btn_level was 1), saturating at 2^DUR_WIDTH-1; no wrap.
- Long press:
  - long_pulse = 1 in cycle N + LONG_PRESS_CYCLES, provided the release has not yet been accepted by then.
  - Fires once per press; saturation does not re-fire it.
  - If R = N + LONG_PRESS_CYCLES exactly, release wins and long_pulse does not fire.
- Result handshake (all registered; updates become visible in cycle R, together with release_pulse):
  - On release: dur_count <= measurement, dur_valid <= 1.
  - dur_ack = 1 while dur_valid = 1 -> dur_valid = 0 and dur_overrun = 0 next cycle; dur_count holds its value.
  - dur_ack while dur_valid = 0 is ignored.
  - Release while dur_valid = 1 and no ack: overwrite dur_count, set dur_overrun = 1.
  - Release and ack in the same cycle: new data is loaded, dur_valid stays 1, dur_overrun is not set.
- press_pulse, release_pulse and long_pulse are never asserted in the same cycle.

Test Plan (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, DUR_WIDTH=8, ACTIVE_LOW=1):
- Reset, btn_in=1 idle for 50 cycles -> all outputs 0; then btn_in=0 pulses of 1-3 cycles -> no press_pulse, btn_level stays 0.
- btn_in=0 held 10 cycles then 1 -> press_pulse exactly 6 cycles after the falling edge (2 sync + 4 debounce); release_pulse 6 cycles after the rising edge; dur_count=10, dur_valid=1, long_pulse never.
- btn_in=0 held 30 cycles -> long_pulse exactly 20 cycles after press_pulse, once; on release dur_count=30.
- Bounce during release: after press, btn_in=1 for 2 cycles, 0 for 3, then 1 steady -> a single release_pulse; duration includes the bounce window; no second press_pulse.
- Two presses without ack -> dur_overrun=1 and dur_count = second duration; dur_ack -> dur_valid=0, dur_overrun=0. Second release coinciding with ack -> dur_valid=1, dur_overrun=0.
- Hold 300 cycles -> dur_count=255 (saturation); assert rst_n=0 mid-press -> all outputs 0 immediately; release after deassertion -> no release_pulse.

Source files
------------

// File: rtl/button_input_reader.sv
// rtl/button_input_reader.sv - synchronised, debounced pushbutton with press/release/long-press events
// and a press-duration result held under a valid/ack handshake.
module button_input_reader #(
  parameter int DEBOUNCE_CYCLES   = 20800,
  parameter int LONG_PRESS_CYCLES = 2080000,
  parameter int DUR_WIDTH         = 24,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_in,
  output logic                 btn_level,
  output logic                 press_pulse,
  output logic                 release_pulse,
  output logic                 long_pulse,
  output logic                 dur_valid,
  output logic [DUR_WIDTH-1:0] dur_count,
  input  logic                 dur_ack,
  output logic                 dur_overrun
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DUR_WIDTH-1:0] DUR_MAX = '1;

  typedef enum logic [1:0] {IDLE, PRESS_DEB, PRESSED, RELEASE_DEB} state_t;

  state_t               state;
  logic                 s_meta;
  logic                 s_sync;
  logic [CW-1:0]        deb_cnt;
  logic [DUR_WIDTH-1:0] dur_cnt;
  logic                 long_done;

  logic [DUR_WIDTH-1:0] dur_next;
  logic                 deb_done;
  logic                 release_now;

  // The entry sample counts as the first stable sample, so acceptance is one short of the full count.
  assign deb_done    = (deb_cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign dur_next    = (dur_cnt == DUR_MAX) ? DUR_MAX : dur_cnt + DUR_WIDTH'(1);
  assign release_now = (state == RELEASE_DEB) && !s_sync && deb_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      s_meta        <= 1'b0;
      s_sync        <= 1'b0;
      deb_cnt       <= '0;
      dur_cnt       <= '0;
      long_done     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      dur_valid     <= 1'b0;
      dur_count     <= '0;
      dur_overrun   <= 1'b0;
    end else begin
      s_meta        <= btn_in ^ ACTIVE_LOW;
      s_sync        <= s_meta;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;

      case (state)
        IDLE: begin
          if (s_sync) begin
            state   <= PRESS_DEB;
            deb_cnt <= CW'(1);
          end
        end
        PRESS_DEB: begin
          if (!s_sync) begin
            state   <= IDLE;
            deb_cnt <= '0;
          end else if (deb_done) begin
            state       <= PRESSED;
            deb_cnt     <= '0;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
            dur_cnt     <= '0;
            long_done   <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (!s_sync) begin
            state   <= RELEASE_DEB;
            deb_cnt <= CW'(1);
          end
        end
        RELEASE_DEB: begin
          if (s_sync) begin
            state   <= PRESSED;
            deb_cnt <= '0;
          end else if (deb_done) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          deb_cnt <= '0;
        end
      endcase

      // Duration keeps running through release bounce; a release on the long-press cycle suppresses it.
      if (state == PRESSED || state == RELEASE_DEB) begin
        dur_cnt <= dur_next;
        if (!release_now && !long_done && (32'(dur_next) == LONG_PRESS_CYCLES)) begin
          long_pulse <= 1'b1;
          long_done  <= 1'b1;
        end
      end

      if (release_now) begin
        dur_count <= dur_next;
        dur_valid <= 1'b1;
        if (dur_valid) begin
          dur_overrun <= !dur_ack;
        end
      end else if (dur_ack && dur_valid) begin
        dur_valid   <= 1'b0;
        dur_overrun <= 1'b0;
      end
    end
  end

endmodule
